wc_tile_streamer: RTL and testbench



---
 rtl/wc_tile_streamer_if.sv | 33 +++
 rtl/wc_tile_streamer.sv | 175 +++++++++++++++++
 tb/tb_wc_tile_streamer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/wc_tile_streamer_if.sv
// wc_tile_streamer_if
//   Bundles the sample-input channel and the tile-output (D) channel of the
//   tile streamer.
//   master : the streamer itself (accepts samples, drives tiles)
//   slave  : the environment (sample source plus D consumer)
//   Signals:
//     s_valid/s_ready/s_data/s_last : serial sample stream, valid/ready
//     D_valid/D_ready/D             : packed LANES*DW tile, valid/ready
//     D_first/D_last                : tile is first/last of its row
interface wc_tile_streamer_if #(
    parameter int DW    = 10,
    parameter int LANES = 5
);
    logic                s_valid;
    logic                s_ready;
    logic [DW-1:0]       s_data;
    logic                s_last;
    logic                D_valid;
    logic                D_ready;
    logic [LANES*DW-1:0] D;
    logic                D_first;
    logic                D_last;

    modport master (
        input  s_valid, s_data, s_last, D_ready,
        output s_ready, D_valid, D, D_first, D_last
    );

    modport slave (
        output s_valid, s_data, s_last, D_ready,
        input  s_ready, D_valid, D, D_first, D_last
    );
endinterface

// File: rtl/wc_tile_streamer.sv
// wc_tile_streamer
//   Turns a serial stream of DW-bit samples into overlapping LANES-sample
//   tiles (stride STRIDE) for the Winograd F(2,4) core D port. Row tails are
//   zero-padded so every sample lands in some tile.
//   Ports:
//     clk       : clock
//     rst       : asynchronous active-low reset
//     bus       : wc_tile_streamer_if.master (sample in, tile out)
//     tile_cnt  : (WC_STREAM_PERF_EN only) count of D transfers, wraps
//     stall_cnt : (WC_STREAM_PERF_EN only) cycles with D_valid & !D_ready
//   Optional feature macro: WC_STREAM_PERF_EN
module wc_tile_streamer #(
    parameter int DW     = 10,
    parameter int LANES  = 5,
    parameter int STRIDE = 2
) (
    input  logic              clk,
    input  logic              rst,
    wc_tile_streamer_if.master bus
`ifdef WC_STREAM_PERF_EN
    ,
    output logic [15:0]       tile_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int CW = $clog2(LANES + 1);
    localparam int IW = $clog2(LANES);

    typedef enum logic [1:0] {FILL, STEP, FLUSH} state_t;

    state_t                     state_q;
    logic                       run_q;
    logic [CW-1:0]              fill_cnt_q;
    logic [CW-1:0]              step_cnt_q;
    logic [CW-1:0]              pad_n_q;
    logic                       row_start_q;
    logic [LANES-1:0][DW-1:0]   win_q;
    logic [LANES-1:0][DW-1:0]   win_sh;
    logic [LANES-1:0][DW-1:0]   win_pad;
    logic                       dv_q;
    logic                       df_q;
    logic                       dl_q;
    logic [LANES*DW-1:0]        d_q;
    logic                       out_free;
    logic                       accept;

    assign out_free = !dv_q || bus.D_ready;
    // run_q is cleared asynchronously by reset, so s_ready is low while in
    // reset without using the reset net as a data input.
    assign bus.s_ready = run_q && (state_q == FILL || state_q == STEP) && out_free;
    assign accept      = bus.s_valid && bus.s_ready;

    // Newest sample enters at lane LANES-1, oldest (lane 0) drops out.
    assign win_sh = {bus.s_data, win_q[LANES-1:1]};

    // Flush tile: window moved toward lane 0 by pad_n, zeros fill the top.
    always_comb begin
        win_pad = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (k + 32'(pad_n_q) < LANES)
                win_pad[IW'(k)] = win_q[IW'(k + 32'(pad_n_q))];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            run_q       <= 1'b0;
            fill_cnt_q  <= '0;
            step_cnt_q  <= '0;
            pad_n_q     <= '0;
            // Reset leaves the block at a row boundary, so the next tile is a row start.
            row_start_q <= 1'b1;
            win_q       <= '0;
            dv_q        <= 1'b0;
            df_q        <= 1'b0;
            dl_q        <= 1'b0;
            d_q         <= '0;
        end else begin
            run_q <= 1'b1;
            if (bus.D_ready) dv_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (accept) begin
                        win_q <= win_sh;
                        if (fill_cnt_q == CW'(LANES - 1)) begin
                            d_q        <= win_sh;
                            dv_q       <= 1'b1;
                            df_q       <= row_start_q;
                            dl_q       <= bus.s_last;
                            fill_cnt_q <= '0;
                            step_cnt_q <= '0;
                            if (bus.s_last) begin
                                row_start_q <= 1'b1;
                                state_q     <= FILL;
                            end else begin
                                row_start_q <= 1'b0;
                                state_q     <= STEP;
                            end
                        end else begin
                            fill_cnt_q <= fill_cnt_q + 1'b1;
                            if (bus.s_last) begin
                                pad_n_q <= CW'(LANES - 1) - fill_cnt_q;
                                state_q <= FLUSH;
                            end
                        end
                    end
                end
                STEP: begin
                    if (accept) begin
                        win_q <= win_sh;
                        if (step_cnt_q == CW'(STRIDE - 1)) begin
                            d_q        <= win_sh;
                            dv_q       <= 1'b1;
                            df_q       <= 1'b0;
                            dl_q       <= bus.s_last;
                            step_cnt_q <= '0;
                            if (bus.s_last) begin
                                row_start_q <= 1'b1;
                                fill_cnt_q  <= '0;
                                state_q     <= FILL;
                            end else begin
                                row_start_q <= 1'b0;
                            end
                        end else begin
                            step_cnt_q <= step_cnt_q + 1'b1;
                            if (bus.s_last) begin
                                pad_n_q <= CW'(STRIDE - 1) - step_cnt_q;
                                state_q <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        d_q         <= win_pad;
                        dv_q        <= 1'b1;
                        df_q        <= row_start_q;
                        dl_q        <= 1'b1;
                        fill_cnt_q  <= '0;
                        step_cnt_q  <= '0;
                        row_start_q <= 1'b1;
                        state_q     <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.D_valid = dv_q;
    assign bus.D       = d_q;
    assign bus.D_first = df_q;
    assign bus.D_last  = dl_q;

`ifdef WC_STREAM_PERF_EN
    logic [15:0] tile_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tile_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (dv_q && bus.D_ready)  tile_cnt_q  <= tile_cnt_q + 16'd1;
            if (dv_q && !bus.D_ready) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign tile_cnt  = tile_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wc_tile_streamer.sv
// tb_wc_tile_streamer
//   Directed bench for wc_tile_streamer: reset state, exact-fit rows, padded
//   row tails, back-pressure and mid-row reset. Counter ports are covered
//   when WC_STREAM_PERF_EN is defined.
module tb_wc_tile_streamer;

    localparam int DW     = 10;
    localparam int LANES  = 5;
    localparam int STRIDE = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    wc_tile_streamer_if #(.DW(DW), .LANES(LANES)) bus ();

`ifdef WC_STREAM_PERF_EN
    logic [15:0] tile_cnt;
    logic [15:0] stall_cnt;
`endif

    wc_tile_streamer #(.DW(DW), .LANES(LANES), .STRIDE(STRIDE)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef WC_STREAM_PERF_EN
        ,
        .tile_cnt(tile_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [LANES*DW-1:0] tile(input logic [DW-1:0] l0, l1, l2, l3, l4);
        return {l4, l3, l2, l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tile(input string tag, input logic [LANES*DW-1:0] d,
                            input logic f, input logic l);
        chk({tag, "_valid"}, 64'(bus.D_valid), 64'd1);
        chk({tag, "_data"},  64'(bus.D),       64'(d));
        chk({tag, "_first"}, 64'(bus.D_first), 64'(f));
        chk({tag, "_last"},  64'(bus.D_last),  64'(l));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(bus.D_valid), 64'd0);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample and return 1 time unit after the edge that accepts it.
    task automatic send(input logic [DW-1:0] d, input logic last);
        int n;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        #1;
        n = 0;
        while (!bus.s_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("s_ready_wait", 64'(n < 40), 64'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    initial begin
        bus.s_valid = 1'b1;
        bus.s_data  = 10'd7;
        bus.s_last  = 1'b0;
        bus.D_ready = 1'b1;
        rst         = 1'b0;

        // Reset state, with a sample offered to show it is refused.
        #2;
        chk("rst_D_valid", 64'(bus.D_valid), 64'd0);
        chk("rst_D",       64'(bus.D),       64'd0);
        chk("rst_D_first", 64'(bus.D_first), 64'd0);
        chk("rst_D_last",  64'(bus.D_last),  64'd0);
        chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        bus.s_valid = 1'b0;
        rst = 1'b1;
        idle();
        idle();

        // Row 1..5: one exact-fit tile.
        for (int i = 1; i <= 4; i++) send(10'(i), 1'b0);
        chk_idle("A_pre");
        send(10'd5, 1'b1);
        chk_tile("A_t0", tile(1, 2, 3, 4, 5), 1'b1, 1'b1);
        idle();
        chk_idle("A_post");

        // Row 1..9: three tiles, no flush.
        for (int i = 1; i <= 4; i++) send(10'(i), 1'b0);
        send(10'd5, 1'b0);
        chk_tile("B_t0", tile(1, 2, 3, 4, 5), 1'b1, 1'b0);
        send(10'd6, 1'b0);
        chk_idle("B_gap");
        send(10'd7, 1'b0);
        chk_tile("B_t1", tile(3, 4, 5, 6, 7), 1'b0, 1'b0);
        send(10'd8, 1'b0);
        send(10'd9, 1'b1);
        chk_tile("B_t2", tile(5, 6, 7, 8, 9), 1'b0, 1'b1);
        idle();
        chk_idle("B_noflush");
        chk("B_s_ready", 64'(bus.s_ready), 64'd1);

        // Row 1..8: tail padded with one zero sample.
        for (int i = 1; i <= 5; i++) send(10'(i), 1'b0);
        send(10'd6, 1'b0);
        send(10'd7, 1'b0);
        chk_tile("C_t1", tile(3, 4, 5, 6, 7), 1'b0, 1'b0);
        send(10'd8, 1'b1);
        chk_idle("C_flush_wait");
        chk("C_flush_s_ready", 64'(bus.s_ready), 64'd0);
        idle();
        chk_tile("C_flush", tile(5, 6, 7, 8, 0), 1'b0, 1'b1);
        idle();
        chk_idle("C_post");

        // Short row 1,2,3.
        send(10'd1, 1'b0);
        send(10'd2, 1'b0);
        send(10'd3, 1'b1);
        chk_idle("D_flush_wait");
        idle();
        chk_tile("D_flush", tile(1, 2, 3, 0, 0), 1'b1, 1'b1);
        idle();

        // Following row starts afresh.
        for (int i = 20; i <= 23; i++) send(10'(i), 1'b0);
        send(10'd24, 1'b1);
        chk_tile("E_t0", tile(20, 21, 22, 23, 24), 1'b1, 1'b1);
        idle();
`ifdef WC_STREAM_PERF_EN
        chk("perf_tiles_9", 64'(tile_cnt), 64'd9);
        chk("perf_stall_0", 64'(stall_cnt), 64'd0);
`endif

        // Back-pressure for 10 cycles with the next sample offered.
        bus.D_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(10'(i), 1'b0);
        chk_tile("F_t0", tile(1, 2, 3, 4, 5), 1'b1, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = 10'd6;
        bus.s_last  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("F_hold_data",    64'(bus.D),       64'(tile(1, 2, 3, 4, 5)));
            chk("F_hold_valid",   64'(bus.D_valid), 64'd1);
            chk("F_hold_s_ready", 64'(bus.s_ready), 64'd0);
            idle();
        end
`ifdef WC_STREAM_PERF_EN
        chk("perf_stall_10", 64'(stall_cnt), 64'd10);
        chk("perf_tiles_hold", 64'(tile_cnt), 64'd9);
`endif
        bus.D_ready = 1'b1;
        send(10'd6, 1'b0);
        chk_idle("F_after_release");
        send(10'd7, 1'b0);
        chk_tile("F_t1", tile(3, 4, 5, 6, 7), 1'b0, 1'b0);
        send(10'd8, 1'b0);
        send(10'd9, 1'b1);
        chk_tile("F_t2", tile(5, 6, 7, 8, 9), 1'b0, 1'b1);
        idle();
`ifdef WC_STREAM_PERF_EN
        chk("perf_tiles_12", 64'(tile_cnt), 64'd12);
`endif

        // Reset with a tile pending and a row in progress.
        for (int i = 30; i <= 34; i++) send(10'(i), 1'b0);
        chk_tile("G_t0", tile(30, 31, 32, 33, 34), 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        chk("G_rst_valid",   64'(bus.D_valid), 64'd0);
        chk("G_rst_D",       64'(bus.D),       64'd0);
        chk("G_rst_s_ready", 64'(bus.s_ready), 64'd0);
`ifdef WC_STREAM_PERF_EN
        chk("perf_rst_tiles", 64'(tile_cnt), 64'd0);
`endif
        #2;
        rst = 1'b1;
        idle();
        idle();
        for (int i = 10; i <= 13; i++) send(10'(i), 1'b0);
        chk_idle("H_pre");
        send(10'd14, 1'b1);
        chk_tile("H_t0", tile(10, 11, 12, 13, 14), 1'b1, 1'b1);
        idle();
        chk_idle("H_post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
